// File: rtl/mc_controller_v2.sv
// Multicycle MIPS-subset control unit: Moore FSM with opcode/func decode, ALU control,
// memory wait-state handshake and an illegal-instruction trap path.
module mc_controller_v2 #(
  parameter int unsigned MEM_WAIT_EN = 1,
  parameter int unsigned TRAP_EN     = 1,
  parameter int unsigned ALUOP_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opc,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               MemReady,
  output logic               PCLoad,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               JalSig1,
  output logic               JalSig2,
  output logic               MemToReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic [ALUOP_W-1:0] ALUOperation,
  output logic [2:0]         PCSrc,
  output logic               EPCWrite,
  output logic               Trap
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC_R  = 4'd2;
  localparam logic [3:0] S_ALUWB_R = 4'd3;
  localparam logic [3:0] S_EXEC_I  = 4'd4;
  localparam logic [3:0] S_ALUWB_I = 4'd5;
  localparam logic [3:0] S_MEMADR  = 4'd6;
  localparam logic [3:0] S_MEMRD   = 4'd7;
  localparam logic [3:0] S_MEMWB   = 4'd8;
  localparam logic [3:0] S_MEMWR   = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_JAL     = 4'd12;
  localparam logic [3:0] S_JR      = 4'd13;
  localparam logic [3:0] S_TRAP    = 4'd14;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] S_ILLEGAL = (TRAP_EN != 0) ? S_TRAP : S_FETCH;

  logic [3:0] r_state;
  logic [2:0] r_aluop;
  logic       r_extop;
  logic       r_is_sw;
  logic       r_is_bne;

  logic [3:0] w_next;
  logic [3:0] w_dec_next;
  logic [2:0] w_dec_aluop;
  logic       w_dec_extop;
  logic       w_dec_sw;
  logic       w_dec_bne;
  logic       w_rdy;
  logic [2:0] w_alu;

  // Memory completion; a single-cycle memory is always ready.
  assign w_rdy = (MEM_WAIT_EN == 0) || MemReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Instruction class is latched in DECODE so later states do not depend on the IR bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aluop  <= ALU_ADD;
      r_extop  <= 1'b0;
      r_is_sw  <= 1'b0;
      r_is_bne <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_aluop  <= w_dec_aluop;
      r_extop  <= w_dec_extop;
      r_is_sw  <= w_dec_sw;
      r_is_bne <= w_dec_bne;
    end
  end

  always_comb begin
    w_dec_next  = S_ILLEGAL;
    w_dec_aluop = ALU_ADD;
    w_dec_extop = 1'b0;
    w_dec_sw    = 1'b0;
    w_dec_bne   = 1'b0;
    case (opc)
      OP_R: begin
        case (func)
          FN_JR:  w_dec_next = S_JR;
          FN_ADD: begin w_dec_next = S_EXEC_R; w_dec_aluop = ALU_ADD; end
          FN_SUB: begin w_dec_next = S_EXEC_R; w_dec_aluop = ALU_SUB; end
          FN_AND: begin w_dec_next = S_EXEC_R; w_dec_aluop = ALU_AND; end
          FN_OR:  begin w_dec_next = S_EXEC_R; w_dec_aluop = ALU_OR;  end
          FN_SLT: begin w_dec_next = S_EXEC_R; w_dec_aluop = ALU_SLT; end
          default: w_dec_next = S_ILLEGAL;
        endcase
      end
      OP_LW:   w_dec_next = S_MEMADR;
      OP_SW:   begin w_dec_next = S_MEMADR; w_dec_sw = 1'b1; end
      OP_ADDI: begin w_dec_next = S_EXEC_I; w_dec_aluop = ALU_ADD; end
      OP_ANDI: begin w_dec_next = S_EXEC_I; w_dec_aluop = ALU_AND; w_dec_extop = 1'b1; end
      OP_ORI:  begin w_dec_next = S_EXEC_I; w_dec_aluop = ALU_OR;  w_dec_extop = 1'b1; end
      OP_SLTI: begin w_dec_next = S_EXEC_I; w_dec_aluop = ALU_SLT; end
      OP_BEQ:  w_dec_next = S_BRANCH;
      OP_BNE:  begin w_dec_next = S_BRANCH; w_dec_bne = 1'b1; end
      OP_J:    w_dec_next = S_JUMP;
      OP_JAL:  w_dec_next = S_JAL;
      default: w_dec_next = S_ILLEGAL;
    endcase
  end

  // Next state and Moore outputs; everything is held at zero while reset is asserted.
  always_comb begin
    w_next    = r_state;
    w_alu     = ALU_AND;
    PCLoad    = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    JalSig1   = 1'b0;
    JalSig2   = 1'b0;
    MemToReg  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ExtOp     = 1'b0;
    PCSrc     = 3'b000;
    EPCWrite  = 1'b0;
    Trap      = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        w_alu   = ALU_ADD;
        IRWrite = w_rdy;
        PCLoad  = w_rdy;
        if (w_rdy) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        w_alu   = ALU_ADD;
        w_next  = w_dec_next;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        w_alu   = r_aluop;
        w_next  = S_ALUWB_R;
      end
      S_ALUWB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = r_extop;
        w_alu   = r_aluop;
        w_next  = S_ALUWB_I;
      end
      S_ALUWB_I: begin
        ExtOp    = r_extop;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_alu   = ALU_ADD;
        w_next  = r_is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (w_rdy) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (w_rdy) w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        w_alu   = ALU_SUB;
        PCSrc   = 3'b001;
        PCLoad  = r_is_bne ? !zero : zero;
        w_next  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc  = 3'b010;
        PCLoad = 1'b1;
        w_next = S_FETCH;
      end
      S_JAL: begin
        PCSrc    = 3'b010;
        PCLoad   = 1'b1;
        JalSig1  = 1'b1;
        JalSig2  = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_JR: begin
        PCSrc  = 3'b011;
        PCLoad = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP: begin
        EPCWrite = 1'b1;
        Trap     = 1'b1;
        PCSrc    = 3'b100;
        PCLoad   = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (!rst) begin
      w_alu    = ALU_AND;
      PCLoad   = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      JalSig1  = 1'b0;
      JalSig2  = 1'b0;
      MemToReg = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ExtOp    = 1'b0;
      PCSrc    = 3'b000;
      EPCWrite = 1'b0;
      Trap     = 1'b0;
    end
  end

  assign ALUOperation = ALUOP_W'(w_alu);

endmodule
